// File: rtl/enc_pkg.sv
// Shared constants and helpers for the registered 8-to-3 encoder family.
package enc_pkg;

   localparam int N_IN     = 8;
   localparam int IDX_W    = 3;
   localparam int RR_FIXED = 0;
   localparam int RR_ROUND = 1;

   // Binary index of a one-hot vector; an all-zero input maps to index 0.
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_IN-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (oh[i]) idx = idx | IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/pri_mask_search.sv
// Combinational request search: highest set index (mode=0) or first set
// index at or above a start position, wrapping (mode=1).
module pri_mask_search
   import enc_pkg::*;
(
   input  logic [N_IN-1:0]  vec,
   input  logic [IDX_W-1:0] start,
   input  logic             mode,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [N_IN-1:0] rot;
   logic [N_IN-1:0] rot_lsb;
   logic [N_IN-1:0] rev;
   logic [N_IN-1:0] rev_lsb;

   // NOTE: every output of a combinational block gets a value on every path,
   // otherwise synthesis infers a latch to hold the old one.
   always_comb begin
      rot = '0;
      rev = '0;
      for (int i = 0; i < N_IN; i++) begin
         rot[i] = vec[IDX_W'(i) + start];
         rev[i] = vec[N_IN-1-i];
      end
      // x & -x isolates the lowest set bit of the rotated / reversed vector.
      rot_lsb = rot & (~rot + N_IN'(1));
      rev_lsb = rev & (~rev + N_IN'(1));
      found   = |vec;
      if (mode) idx = onehot_to_idx(rot_lsb) + start;
      else      idx = IDX_W'(N_IN-1) - onehot_to_idx(rev_lsb);
   end

endmodule

// File: rtl/encoder8x3_seq.sv
// Registered 8-to-3 encoder: captures request strobes into a pending set and
// presents them one at a time as a binary index under a valid/ready handshake.
module encoder8x3_seq
   import enc_pkg::*;
#(
   parameter int RR_MODE = RR_FIXED
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_IN-1:0]  D,
   input  logic             E,
   input  logic             rdy,
   output logic [IDX_W-1:0] Y,
   output logic             V,
   output logic             OVF,
   output logic             IDLE
);

   localparam logic MODE_BIT = (RR_MODE == RR_ROUND);

   logic [N_IN-1:0]  pend;
   logic [IDX_W-1:0] last;
   logic             transfer;
   logic [N_IN-1:0]  clr;
   logic [N_IN-1:0]  avail;
   logic [N_IN-1:0]  pend_next;
   logic             ovf_next;
   logic             load;
   logic [IDX_W-1:0] start;
   logic             found;
   logic [IDX_W-1:0] sel_idx;

   always_comb begin
      transfer  = V && rdy;
      clr       = transfer ? (N_IN'(1) << Y) : '0;
      avail     = pend & ~clr;
      pend_next = avail | (E ? D : '0);
      ovf_next  = E && |(D & avail);
      load      = !V || transfer;
      // The code leaving this cycle counts as the last grant for the new search.
      start     = (transfer ? Y : last) + IDX_W'(1);
   end

   pri_mask_search u_search (
      .vec   (avail),
      .start (start),
      .mode  (MODE_BIT),
      .found (found),
      .idx   (sel_idx)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
         Y    <= '0;
         V    <= 1'b0;
         OVF  <= 1'b0;
         last <= IDX_W'(N_IN-1);
      end else begin
         pend <= pend_next;
         OVF  <= ovf_next;
         if (transfer) last <= Y;
         if (load) begin
            if (found) begin
               Y <= sel_idx;
               V <= 1'b1;
            end else begin
               V <= 1'b0;
            end
         end
      end
   end

   assign IDLE = (pend == '0) && !V;

endmodule

// File: tb/tb_encoder8x3_seq.sv
// Directed bench for encoder8x3_seq: a fixed-priority and a round-robin
// instance share stimulus and are checked against hand-computed codes.
module tb_encoder8x3_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] D;
   logic       E;
   logic       rdy;

   logic [2:0] y_fix, y_rr;
   logic       v_fix, v_rr;
   logic       ovf_fix, ovf_rr;
   logic       idle_fix, idle_rr;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   encoder8x3_seq #(.RR_MODE(0)) u_fix (
      .clk (clk), .rst_n (rst_n), .D (D), .E (E), .rdy (rdy),
      .Y (y_fix), .V (v_fix), .OVF (ovf_fix), .IDLE (idle_fix)
   );

   encoder8x3_seq #(.RR_MODE(1)) u_rr (
      .clk (clk), .rst_n (rst_n), .D (D), .E (E), .rdy (rdy),
      .Y (y_rr), .V (v_rr), .OVF (ovf_rr), .IDLE (idle_rr)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; D = 8'h00; E = 1'b0; rdy = 1'b0;
      step(); step();
      rst_n = 1'b1;
      check("rst_y_fix", y_fix, 8'd0);
      check("rst_v_fix", v_fix, 8'd0);
      check("rst_ovf_fix", ovf_fix, 8'd0);
      check("rst_idle_fix", idle_fix, 8'd1);
      check("rst_idle_rr", idle_rr, 8'd1);

      // Asynchronous reset with everything pending, a code presented and OVF high
      E = 1'b1; rdy = 1'b0; D = 8'hFF;
      step(); D = 8'h00;
      step();
      check("t1_v_fix", v_fix, 8'd1);
      check("t1_y_fix", y_fix, 8'd7);
      check("t1_y_rr", y_rr, 8'd0);
      D = 8'hFF;
      step(); D = 8'h00;
      check("t1_ovf_fix", ovf_fix, 8'd1);
      check("t1_ovf_rr", ovf_rr, 8'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t1_async_y_fix", y_fix, 8'd0);
      check("t1_async_v_fix", v_fix, 8'd0);
      check("t1_async_ovf_fix", ovf_fix, 8'd0);
      check("t1_async_idle_fix", idle_fix, 8'd1);
      check("t1_async_y_rr", y_rr, 8'd0);
      check("t1_async_v_rr", v_rr, 8'd0);
      check("t1_async_idle_rr", idle_rr, 8'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      step();
      check("t1_post_v_fix", v_fix, 8'd0);
      check("t1_post_idle_fix", idle_fix, 8'd1);

      // Enable low: strobes ignored
      E = 1'b0; D = 8'hFF;
      step(); D = 8'h00;
      check("t2_idle_fix_a", idle_fix, 8'd1);
      check("t2_idle_rr_a", idle_rr, 8'd1);
      step();
      check("t2_v_fix", v_fix, 8'd0);
      check("t2_idle_fix_b", idle_fix, 8'd1);

      // Multi-hot request drained at full rate
      E = 1'b1; rdy = 1'b1; D = 8'b1010_0100;
      step(); D = 8'h00;
      check("t3_lat_v_fix", v_fix, 8'd0);
      check("t3_lat_idle_fix", idle_fix, 8'd0);
      step();
      check("t3_v0_fix", v_fix, 8'd1);
      check("t3_y0_fix", y_fix, 8'd7);
      check("t3_y0_rr", y_rr, 8'd2);
      step();
      check("t3_v1_fix", v_fix, 8'd1);
      check("t3_y1_fix", y_fix, 8'd5);
      check("t3_y1_rr", y_rr, 8'd5);
      step();
      check("t3_v2_fix", v_fix, 8'd1);
      check("t3_y2_fix", y_fix, 8'd2);
      check("t3_y2_rr", y_rr, 8'd7);
      step();
      check("t3_end_v_fix", v_fix, 8'd0);
      check("t3_end_idle_fix", idle_fix, 8'd1);
      check("t3_end_idle_rr", idle_rr, 8'd1);

      // Round-robin order from reset, then wrap from last=7 back to 0
      do_reset();
      D = 8'b1000_0011;
      step(); D = 8'h00;
      step();
      check("t4_a0_rr", y_rr, 8'd0);
      check("t4_a0_fix", y_fix, 8'd7);
      step();
      check("t4_a1_rr", y_rr, 8'd1);
      check("t4_a1_fix", y_fix, 8'd1);
      step();
      check("t4_a2_rr", y_rr, 8'd7);
      check("t4_a2_fix", y_fix, 8'd0);
      check("t4_a2_v_rr", v_rr, 8'd1);
      step();
      check("t4_a_end_v_rr", v_rr, 8'd0);
      D = 8'b1000_0001;
      step(); D = 8'h00;
      step();
      check("t4_b0_rr", y_rr, 8'd0);
      check("t4_b0_fix", y_fix, 8'd7);
      step();
      check("t4_b1_rr", y_rr, 8'd7);
      check("t4_b1_fix", y_fix, 8'd0);
      step();
      check("t4_b_end_v_rr", v_rr, 8'd0);
      check("t4_b_end_idle_rr", idle_rr, 8'd1);

      // Backpressure holds the code; a repeat strobe raises a one-cycle OVF
      rdy = 1'b0; D = 8'h10;
      step(); D = 8'h00;
      step();
      for (int i = 0; i < 5; i++) begin
         check("t5_hold_v_fix", v_fix, 8'd1);
         check("t5_hold_y_fix", y_fix, 8'd4);
         check("t5_hold_y_rr", y_rr, 8'd4);
         check("t5_hold_ovf_fix", ovf_fix, 8'd0);
         step();
      end
      D = 8'h10;
      step(); D = 8'h00;
      check("t5_ovf_fix", ovf_fix, 8'd1);
      check("t5_ovf_rr", ovf_rr, 8'd1);
      check("t5_ovf_y_fix", y_fix, 8'd4);
      step();
      check("t5_ovf_pulse_fix", ovf_fix, 8'd0);
      check("t5_still_v_fix", v_fix, 8'd1);
      rdy = 1'b1;
      step();
      check("t5_drain_v_fix", v_fix, 8'd0);
      check("t5_drain_idle_fix", idle_fix, 8'd1);
      check("t5_drain_v_rr", v_rr, 8'd0);

      // Transfer and re-request of the same bit in one cycle
      D = 8'h08;
      step(); D = 8'h00;
      step();
      check("t6_pre_v_fix", v_fix, 8'd1);
      check("t6_pre_y_fix", y_fix, 8'd3);
      check("t6_pre_y_rr", y_rr, 8'd3);
      D = 8'h08;
      step(); D = 8'h00;
      check("t6_ovf_fix", ovf_fix, 8'd0);
      check("t6_gap_v_fix", v_fix, 8'd0);
      check("t6_gap_idle_fix", idle_fix, 8'd0);
      step();
      check("t6_again_v_fix", v_fix, 8'd1);
      check("t6_again_y_fix", y_fix, 8'd3);
      check("t6_again_y_rr", y_rr, 8'd3);
      step();
      check("t6_end_v_fix", v_fix, 8'd0);
      check("t6_end_idle_fix", idle_fix, 8'd1);
      check("t6_end_idle_rr", idle_rr, 8'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/encoder8x3_seq.md
Name: encoder8x3_seq

Overview:
Registered 8-to-3 encoder. It is the return path for the 3x8 decoder family: one-hot or multi-hot request pulses on D are captured into a pending register. Pending requests are then presented one at a time as a 3-bit code Y with a valid/ready handshake. The block sits between decoded-strobe sources and any consumer that needs a binary index.

Parameters:
RR_MODE, 0, 0 = fixed priority (highest index wins); 1 = round-robin (search starts one above the last granted index, wrapping 7->0)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
D  input  8  request strobes; bit i requests code i
E  input  1  enable; when 0, D is ignored (pending requests still drain)
rdy  input  1  consumer ready
Y  output  3  encoded index of the presented request
V  output  1  Y valid
OVF  output  1  one-cycle pulse: a request hit an already-pending bit
IDLE  output  1  high when pending==0 and V==0 (combinational from registers)

Behaviour:
- Reset (rst_n low, asynchronous): pend=8'h00, Y=3'b000, V=0, OVF=0, last=3'd7; IDLE reads 1.
- Handshake: a transfer occurs on an edge where V && rdy. Y and V hold stable while V && !rdy.
- Pending update at each edge: pend_next = (pend & ~clr) | (E ? D : 8'h00).
  - clr = onehot(Y) when a transfer occurs, else 0.
  - Same-cycle clear and new D on the same bit: the bit stays set (counted as a new request, no OVF).
- OVF next cycle = 1 iff E && |(D & pend & ~clr); otherwise 0. OVF is a pulse, not sticky.
- Output load: when !V or a transfer occurs, search avail = pend & ~clr.
  - avail != 0: Y <= selected index, V <= 1.
  - avail == 0: V <= 0, Y holds.
  - D arriving in the same cycle is not visible to the search.
- Fixed mode: selected = highest set index of avail.
- RR mode: search avail ascending from last+1 mod 8. last <= Y on each transfer. After reset the search starts at index 0.
- Latency: D sampled at edge k -> pend set at edge k -> V=1 after edge k+1, with an empty pipeline.
- Throughput: one code per cycle while rdy is held high and requests are pending.
- The presented bit stays in pend until its transfer, so it is never lost or duplicated.
- E=0 with pending requests: draining continues normally.
- Reset mid-operation drops all pending and presented requests; no transfer is reported.

Decomposition:
- Shared package enc_pkg: constants N_IN=8, IDX_W=3, RR_FIXED=0, RR_ROUND=1, onehot-to-index helper function.
- One combinational sub-module, pri_mask_search:
  - inputs: 8-bit vector, 3-bit start index, mode bit
  - outputs: found flag, 3-bit index
  - Instantiated once for the output-load search.

Test Plan:
1. Reset: rst_n=0 asynchronously mid-cycle with pend=8'hFF, V=1 -> Y=0, V=0, OVF=0, IDLE=1 immediately, without waiting for clk.
2. E=0, D=8'hFF for 1 cycle -> pend stays 0, V stays 0, IDLE=1.
3. Fixed mode, rdy=1, E=1, D=8'b1010_0100 for 1 cycle -> V high for 3 consecutive cycles with Y=7,5,2, then V=0, IDLE=1.
4. RR mode from reset, rdy=1, D=8'b1000_0011 -> Y sequence 0,1,7. Then D=8'b1000_0001 -> Y sequence 0,7 (search from last+1=0 wraps).
5. Backpressure: rdy=0, D=8'h10 -> Y=4, V=1 held 5 cycles. Pulse D=8'h10 again -> OVF=1 for exactly 1 cycle. Raise rdy -> single transfer of Y=4, then V=0.
6. Same-cycle clear and re-request: V=1, Y=3, rdy=1, D=8'h08 -> transfer of 3, OVF=0, next cycle V=1, Y=3 again.
